// File: rtl/map_row_serializer_if.sv
// Pixel-word stream from the row serializer to the display/collision consumer.
// The master drives words and their line/frame qualifiers; the slave drives ready.
interface map_row_serializer_if #(
  parameter int unsigned WORD = 16
);
  logic [WORD-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_eol;
  logic            out_eof;

  modport master (
    output out_data,
    output out_valid,
    output out_eol,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_eol,
    input  out_eof,
    output out_ready
  );
endinterface

// File: rtl/map_row_serializer.sv
// Wall-map row serializer: walks the map generator's row index, latches each
// returned row and streams it MSB-first as WORD-bit pixel words. A one-cycle
// buffer-switch pulse closes every frame so map changes land between frames.
module map_row_serializer #(
  parameter  int unsigned H_BITS = 1696,
  parameter  int unsigned ROWS   = 480,
  parameter  int unsigned WORD   = 16,
  localparam int unsigned WPL    = H_BITS / WORD,
  localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  output logic [RowW-1:0]      o_row,
  input  logic [H_BITS-1:0]    i_row_data,
  output logic                 o_switch_buffer,
  output logic                 o_busy,
  map_row_serializer_if.master out_if
);

  localparam int unsigned WiW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [WiW-1:0]  LastWord = WiW'(WPL - 1);
  localparam logic [RowW-1:0] LastRow  = RowW'(ROWS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StFrameEnd
  } state_e;

  state_e              r_state;
  logic [RowW-1:0]     r_row;
  logic [WiW-1:0]      r_word_idx;
  logic [H_BITS-1:0]   r_shreg;
  logic                r_valid;
  logic                r_eol;
  logic                r_eof;
  logic                r_switch;

  logic                w_accept;
  logic                w_last_word;
  logic                w_last_row;
  logic [WiW-1:0]      w_next_idx;

  assign w_accept    = r_valid & out_if.out_ready;
  assign w_last_word = (r_word_idx == LastWord);
  assign w_last_row  = (r_row == LastRow);
  assign w_next_idx  = r_word_idx + 1'b1;

  // Scan FSM; eol/eof are precomputed for the word about to be presented so
  // all stream qualifiers come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_row      <= '0;
      r_word_idx <= '0;
      r_shreg    <= '0;
      r_valid    <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_switch   <= 1'b0;
    end else begin
      r_switch <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_enable) r_state <= StLoad;
        end
        StLoad: begin
          // row was set on the edge into this state, so row_data is settled.
          r_shreg    <= i_row_data;
          r_word_idx <= '0;
          r_valid    <= 1'b1;
          r_eol      <= (WPL == 1);
          r_eof      <= (WPL == 1) && w_last_row;
          r_state    <= StSend;
        end
        StSend: begin
          if (w_accept) begin
            r_shreg    <= r_shreg << WORD;
            r_word_idx <= w_next_idx;
            if (w_last_word) begin
              r_valid <= 1'b0;
              r_eol   <= 1'b0;
              r_eof   <= 1'b0;
              if (w_last_row) begin
                r_state  <= StFrameEnd;
                r_switch <= 1'b1;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= StLoad;
              end
            end else begin
              r_eol <= (w_next_idx == LastWord);
              r_eof <= (w_next_idx == LastWord) && w_last_row;
            end
          end
        end
        StFrameEnd: begin
          // Pulse is high here with row still at the last row.
          r_row   <= '0;
          r_state <= i_enable ? StLoad : StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_row             = r_row;
  assign o_switch_buffer   = r_switch;
  assign o_busy            = (r_state != StIdle);
  assign out_if.out_data   = r_shreg[H_BITS-1 -: WORD];
  assign out_if.out_valid  = r_valid;
  assign out_if.out_eol    = r_eol;
  assign out_if.out_eof    = r_eof;

endmodule

// File: tb/tb_map_row_serializer.sv
// Self-checking bench for map_row_serializer. Uses a shortened frame (odd row
// count) so several full frames fit in a short run; the cycle formulas are the
// same as for the full-size map.
module tb_map_row_serializer;

  localparam int unsigned H        = 1696;
  localparam int unsigned WORD     = 16;
  localparam int unsigned ROWS     = 13;
  localparam int unsigned WPL      = H / WORD;
  localparam int unsigned RW       = $clog2(ROWS);
  localparam int unsigned FrameCyc = ROWS * (WPL + 1) + 1;
  localparam int unsigned DropRow  = 5;
  localparam int unsigned RstRow   = 10;
  localparam int unsigned RstWord  = 50;

  typedef struct {
    logic [WORD-1:0] d;
    logic            eol;
    logic            eof;
    logic [RW-1:0]   row;
  } exp_t;

  typedef struct {
    int              bitpos;
    int              widx;
    logic [WORD-1:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[6];

  int checks   = 0;
  int failures = 0;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            mode_const = 1'b0;
  logic            sb_en = 1'b0;
  logic            rand_ready = 1'b0;
  logic [H-1:0]    const_pat = '0;
  logic [H-1:0]    row_data;
  logic [RW-1:0]   row;
  logic            sw;
  logic            busy;

  map_row_serializer_if #(.WORD(WORD)) bus ();

  map_row_serializer #(
    .H_BITS(H),
    .ROWS  (ROWS),
    .WORD  (WORD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (enable),
    .o_row          (row),
    .i_row_data     (row_data),
    .o_switch_buffer(sw),
    .o_busy         (busy),
    .out_if         (bus.master)
  );

  always #5 clk = ~clk;

  // Generator model: constant pattern, or every word of row r = {r, 7'b0}.
  always_comb begin
    row_data = '0;
    if (mode_const) row_data = const_pat;
    else for (int k = 0; k < WPL; k++) row_data[k*WORD +: WORD] = {9'(row), 7'b0};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int w = 0; w < WPL; w++) begin
        e.d   = {9'(r), 7'b0};
        e.eol = (w == WPL - 1);
        e.eof = (w == WPL - 1) && (r == ROWS - 1);
        e.row = RW'(r);
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    rand_ready = 1'b0;
    bus.out_ready = 1'b0;
    sb_en = 1'b0;
    repeat (2) tick();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_row", row, '0);
    chk("rst_switch", sw, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_eol_eof", {bus.out_eol, bus.out_eof}, 2'b00);
    sb.delete();
    reset = 1'b0;
  endtask

  // Run until the switch pulse is seen; returns its row and the eof accepts.
  task automatic run_to_switch(input int budget, output bit ok, output logic [RW-1:0] sw_row,
                               output int neof);
    ok = 1'b0;
    neof = 0;
    sw_row = '0;
    for (int c = 0; c < budget && !ok; c++) begin
      if (bus.out_valid && bus.out_ready && bus.out_eof) neof++;
      tick();
      if (sw) begin
        ok = 1'b1;
        sw_row = row;
      end
    end
    if (!ok) chk("timeout_switch", 1'b0, 1'b1);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  initial begin
    logic            p_stall;
    logic [WORD-1:0] p_d;
    logic            p_eol;
    logic            p_eof;
    logic [RW-1:0]   p_row;
    p_stall = 1'b0;
    p_d = '0;
    p_eol = 1'b0;
    p_eof = 1'b0;
    p_row = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_stall = 1'b0;
      end else begin
        if (sb_en && p_stall) begin
          chk("stall_valid", bus.out_valid, 1'b1);
          chk("stall_data", bus.out_data, p_d);
          chk("stall_eol_eof", {bus.out_eol, bus.out_eof}, {p_eol, p_eof});
          chk("stall_row", row, p_row);
        end
        if (sb_en && bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("sb_extra_word", 1'b1, 1'b0);
          end else begin
            mon_e = sb.pop_front();
            chk("sb_data", bus.out_data, mon_e.d);
            chk("sb_eol_eof", {bus.out_eol, bus.out_eof}, {mon_e.eol, mon_e.eof});
            chk("sb_row", row, mon_e.row);
          end
        end
        p_stall = bus.out_valid && !bus.out_ready;
        p_d = bus.out_data;
        p_eol = bus.out_eol;
        p_eof = bus.out_eof;
        p_row = row;
      end
    end
  end

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit              ok;
    logic [RW-1:0]   sw_row;
    int              neof;
    int              nsw;
    int              sw_cyc;
    int              row1_cyc;
    int              nz;
    int              eolbad;
    int              vbad;
    logic [WORD-1:0] got;

    vt[0] = '{1695, 0,   16'h8000};
    vt[1] = '{1680, 0,   16'h0001};
    vt[2] = '{1679, 1,   16'h8000};
    vt[3] = '{16,   104, 16'h0001};
    vt[4] = '{15,   105, 16'h8000};
    vt[5] = '{0,    105, 16'h0001};

    // Single-bit rows: word position, MSB-first order, latency, eol placement.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      mode_const = 1'b1;
      const_pat = '0;
      const_pat[vt[i].bitpos] = 1'b1;
      bus.out_ready = 1'b1;
      enable = 1'b1;
      tick();
      chk("load_valid_low", bus.out_valid, 1'b0);
      chk("load_busy", busy, 1'b1);
      tick();
      nz = 0;
      eolbad = 0;
      vbad = 0;
      got = '0;
      for (int w = 0; w < WPL; w++) begin
        if (!bus.out_valid) vbad++;
        if (bus.out_eol != (w == WPL - 1)) eolbad++;
        if (w == vt[i].widx) got = bus.out_data;
        else if (bus.out_data != '0) nz++;
        tick();
      end
      chk("tbl_word", got, vt[i].exp);
      chk("tbl_other_zero", nz, 0);
      chk("tbl_eol_pos", eolbad, 0);
      chk("tbl_valid_run", vbad, 0);
      chk("tbl_next_row", row, RW'(1));
      chk("tbl_next_load", bus.out_valid, 1'b0);
    end
    mode_const = 1'b0;

    // Full frame, ready high, enable held: timing of lines, eof and the pulse.
    do_reset();
    push_frame();
    sb_en = 1'b1;
    bus.out_ready = 1'b1;
    enable = 1'b1;
    nsw = 0;
    neof = 0;
    sw_cyc = -1;
    row1_cyc = -1;
    sw_row = '0;
    for (int c = 1; c <= FrameCyc + 1; c++) begin
      if (bus.out_valid && bus.out_ready && bus.out_eof) neof++;
      tick();
      if (sw) begin
        nsw++;
        sw_cyc = c;
        sw_row = row;
      end
      if (row == RW'(1) && row1_cyc < 0) row1_cyc = c;
    end
    chk("frame_row1_start", row1_cyc, WPL + 2);
    chk("frame_switch_count", nsw, 1);
    chk("frame_switch_cycle", sw_cyc, FrameCyc);
    chk("frame_switch_row", sw_row, RW'(ROWS - 1));
    chk("frame_eof_count", neof, 1);
    chk("frame_next_load_row", row, '0);
    chk("frame_next_load_busy", busy, 1'b1);
    chk("frame_next_load_valid", bus.out_valid, 1'b0);
    chk("frame_sb_empty", sb.size(), 0);
    sb_en = 1'b0;
    tick();
    chk("frame2_valid", bus.out_valid, 1'b1);
    chk("frame2_row", row, '0);

    // Random backpressure: same word sequence, stable while stalled.
    do_reset();
    push_frame();
    sb_en = 1'b1;
    rand_ready = 1'b1;
    enable = 1'b1;
    run_to_switch(8 * FrameCyc, ok, sw_row, neof);
    enable = 1'b0;
    rand_ready = 1'b0;
    bus.out_ready = 1'b0;
    chk("rand_switch_row", sw_row, RW'(ROWS - 1));
    chk("rand_eof_count", neof, 1);
    chk("rand_sb_empty", sb.size(), 0);
    tick();
    chk("rand_idle_busy", busy, 1'b0);
    chk("rand_idle_valid", bus.out_valid, 1'b0);

    // enable dropped mid-frame: frame completes, one pulse, then idle.
    do_reset();
    push_frame();
    sb_en = 1'b1;
    bus.out_ready = 1'b1;
    enable = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < FrameCyc && !ok; c++) begin
      tick();
      if (row == RW'(DropRow)) ok = 1'b1;
    end
    if (!ok) chk("timeout_drop_row", 1'b0, 1'b1);
    enable = 1'b0;
    run_to_switch(2 * FrameCyc, ok, sw_row, neof);
    chk("drop_switch_row", sw_row, RW'(ROWS - 1));
    tick();
    chk("drop_idle_busy", busy, 1'b0);
    chk("drop_idle_valid", bus.out_valid, 1'b0);
    chk("drop_idle_row", row, '0);
    nsw = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (sw || busy) nsw++;
    end
    chk("drop_stays_idle", nsw, 0);
    chk("drop_sb_empty", sb.size(), 0);

    // Reset while presenting a word mid-frame, then restart from row 0.
    do_reset();
    bus.out_ready = 1'b1;
    enable = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < FrameCyc && !ok; c++) begin
      tick();
      if (row == RW'(RstRow)) ok = 1'b1;
    end
    if (!ok) chk("timeout_rst_row", 1'b0, 1'b1);
    repeat (RstWord + 1) tick();
    chk("mid_word_valid", bus.out_valid, 1'b1);
    chk("mid_word_data", bus.out_data, {9'(RstRow), 7'b0});
    reset = 1'b1;
    tick();
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_row", row, '0);
    chk("midrst_switch", sw, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    push_frame();
    sb_en = 1'b1;
    reset = 1'b0;
    run_to_switch(2 * FrameCyc, ok, sw_row, neof);
    chk("restart_eof_count", neof, 1);
    chk("restart_sb_empty", sb.size(), 0);
    enable = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
